// File: rtl/arb4_mux_sched_if.sv
// Shared-mux arbiter bus: request/release inputs, mux data
// inputs, and the registered grant/select/data outputs.
interface arb4_mux_sched_if;
  logic [3:0] req;
  logic       done;
  logic       i0;
  logic       i1;
  logic       i2;
  logic       i3;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       out;
  logic       busy;

  modport master (
    output req, done, i0, i1, i2, i3,
    input  gnt, s0, s1, out, busy
  );

  modport slave (
    input  req, done, i0, i1, i2, i3,
    output gnt, s0, s1, out, busy
  );
endinterface

// File: rtl/arb4_mux_sched.sv
// 4-way round-robin arbiter owning a shared 4:1 mux (IDLE/GRANT/COOL).
// Optional ARB4_LOCK_EN adds a lock input that suppresses the hold timeout.
module arb4_mux_sched #(
  parameter int HOLD_MAX = 8
) (
  input logic clk,
  input logic rst_n,
`ifdef ARB4_LOCK_EN
  input logic lock,
`endif
  arb4_mux_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COOL
  } state_t;

  localparam logic [7:0] LAST = 8'(HOLD_MAX - 1);

  state_t     state, state_n;
  logic [3:0] gnt_q, gnt_n;
  logic [1:0] sel_q, sel_n;
  logic       out_q, out_n;
  logic [1:0] ptr, ptr_n;
  logic [7:0] cnt, cnt_n;

  logic [1:0] win;
  logic [3:0] din;
  logic       tmo;
  logic       rel;

  assign din = {bus.i3, bus.i2, bus.i1, bus.i0};

`ifdef ARB4_LOCK_EN
  assign tmo = (cnt >= LAST) & ~lock;
`else
  assign tmo = (cnt >= LAST);
`endif

  assign rel = bus.done | ~bus.req[sel_q] | tmo;

  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)])
        win = ptr + 2'(k);
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    out_n   = out_q;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        out_n = 1'b0;
        if (|bus.req) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          cnt_n   = 8'd0;
        end
      end
      GRANT: begin
        out_n = din[sel_q];
        unique case (1'b1)
          rel: begin
            state_n = COOL;
            gnt_n   = 4'b0000;
            out_n   = 1'b0;
            ptr_n   = sel_q + 2'd1;
          end
          default: begin
            if (cnt != 8'hFF)
              cnt_n = cnt + 8'd1;
          end
        endcase
      end
      COOL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= 4'b0000;
      sel_q <= 2'd0;
      out_q <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      sel_q <= sel_n;
      out_q <= out_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s0   = sel_q[1];
  assign bus.s1   = sel_q[0];
  assign bus.out  = out_q;
  assign bus.busy = (state != IDLE);

endmodule
